// File: rtl/pll_div_cntr.sv
// rtl/pll_div_cntr.sv - multi-channel programmable clock-enable divider with glitch-free reconfiguration
module pll_div_cntr #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8,
  localparam int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHANNELS-1:0]  en,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAN_W-1:0]    cfg_chan,
  input  logic [CNT_WIDTH-1:0] cfg_high,
  input  logic [CNT_WIDTH-1:0] cfg_low,
  input  logic [CNT_WIDTH-1:0] cfg_phase,
  input  logic                 cfg_bypass,
  output logic [CHANNELS-1:0]  cout,
  output logic [CHANNELS-1:0]  period_tick
);

  typedef enum logic [1:0] {S_IDLE, S_PHASE, S_HIGH, S_LOW} state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [CHANNELS-1:0] w_hit;
  logic [CHANNELS-1:0] w_pnd_vld;

  always_comb begin
    w_hit     = '0;
    cfg_ready = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_hit[i] = (cfg_chan == CHAN_W'(i));
      if (w_hit[i] && (!w_pnd_vld[i] || reset)) cfg_ready = 1'b1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    state_t               r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_act_high, r_act_low, r_act_phase;
    logic                 r_act_byp;
    logic [CNT_WIDTH-1:0] r_pnd_high, r_pnd_low, r_pnd_phase;
    logic                 r_pnd_byp, r_pnd_vld;
    logic                 r_cout, r_tick;
    logic                 w_cout_nxt, w_tick_nxt, w_promote, w_acc;
    logic [CNT_WIDTH-1:0] w_high_eff, w_low_eff, w_pnd_high_eff, w_bnd_high;

    // Zero counts behave as one so every period spans at least two cycles.
    assign w_high_eff     = (r_act_high == '0) ? ONE : r_act_high;
    assign w_low_eff      = (r_act_low  == '0) ? ONE : r_act_low;
    assign w_pnd_high_eff = (r_pnd_high == '0) ? ONE : r_pnd_high;
    assign w_bnd_high     = r_pnd_vld ? w_pnd_high_eff : w_high_eff;
    assign w_acc          = cfg_valid & cfg_ready & w_hit[g];

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_promote   = 1'b0;
      w_cout_nxt  = 1'b0;
      w_tick_nxt  = 1'b0;
      case (r_state)
        S_IDLE: begin
          w_promote = r_pnd_vld;
          if (r_act_byp) begin
            w_state_nxt = S_HIGH;
          end else if (r_act_phase != '0) begin
            w_state_nxt = S_PHASE;
            w_cnt_nxt   = r_act_phase;
          end else begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = w_high_eff;
          end
        end
        S_PHASE: begin
          if (r_cnt == ONE) begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = w_high_eff;
          end else begin
            w_cnt_nxt = r_cnt - ONE;
          end
        end
        S_HIGH: begin
          w_cout_nxt = 1'b1;
          if (r_act_byp) begin
            // In bypass every cycle closes a period and is a reconfiguration boundary.
            w_tick_nxt = 1'b1;
            w_promote  = r_pnd_vld;
            w_cnt_nxt  = w_bnd_high;
          end else if (r_cnt == ONE) begin
            w_state_nxt = S_LOW;
            w_cnt_nxt   = w_low_eff;
          end else begin
            w_cnt_nxt = r_cnt - ONE;
          end
        end
        S_LOW: begin
          if (r_cnt == ONE) begin
            w_tick_nxt  = 1'b1;
            w_promote   = r_pnd_vld;
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = w_bnd_high;
          end else begin
            w_cnt_nxt = r_cnt - ONE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (!en[g]) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = r_cnt;
        w_cout_nxt  = 1'b0;
        w_tick_nxt  = 1'b0;
        w_promote   = (r_state == S_IDLE) && r_pnd_vld;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        r_act_high  <= ONE;
        r_act_low   <= ONE;
        r_act_phase <= '0;
        r_act_byp   <= 1'b0;
        r_pnd_high  <= '0;
        r_pnd_low   <= '0;
        r_pnd_phase <= '0;
        r_pnd_byp   <= 1'b0;
        r_pnd_vld   <= 1'b0;
        r_cout      <= 1'b0;
        r_tick      <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_cout  <= w_cout_nxt;
        r_tick  <= w_tick_nxt;
        if (w_promote) begin
          r_act_high  <= r_pnd_high;
          r_act_low   <= r_pnd_low;
          r_act_phase <= r_pnd_phase;
          r_act_byp   <= r_pnd_byp;
          r_pnd_vld   <= 1'b0;
        end
        if (w_acc) begin
          r_pnd_high  <= cfg_high;
          r_pnd_low   <= cfg_low;
          r_pnd_phase <= cfg_phase;
          r_pnd_byp   <= cfg_bypass;
          r_pnd_vld   <= 1'b1;
        end
      end
    end

    assign w_pnd_vld[g]   = r_pnd_vld;
    assign cout[g]        = r_cout;
    assign period_tick[g] = r_tick;
  end

endmodule

// File: tb/tb_pll_div_cntr.sv
// tb/tb_pll_div_cntr.sv - self-checking bench for pll_div_cntr
module tb_pll_div_cntr;
  localparam int CH = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] en;
  logic          cfg_valid, cfg_ready, cfg_bypass;
  logic [1:0]    cfg_chan;
  logic [CW-1:0] cfg_high, cfg_low, cfg_phase;
  logic [CH-1:0] cout, period_tick;

  pll_div_cntr #(.CHANNELS(CH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_phase(cfg_phase),
    .cfg_bypass(cfg_bypass), .cout(cout), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  typedef struct {int ch; logic c; logic t; string tag;} exp_t;
  typedef struct {int ch; int h; int l; int p; int n; int lat; int per; int hi;} vec_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input int ch, input logic c, input logic t, input string tag);
    exp_t e;
    e.ch = ch; e.c = c; e.t = t; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic sb_step();
    exp_t e;
    step();
    while (q.size() > 0) begin
      e = q.pop_front();
      check({e.tag, " cout"}, 32'(cout[e.ch]), 32'(e.c));
      check({e.tag, " tick"}, 32'(period_tick[e.ch]), 32'(e.t));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; en = '0; cfg_valid = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic drive_cfg(input int ch, input int h, input int l, input int p, input bit b);
    cfg_chan = 2'(ch); cfg_high = CW'(h); cfg_low = CW'(l); cfg_phase = CW'(p);
    cfg_bypass = b; cfg_valid = 1'b1;
    #1;
  endtask

  task automatic write_cfg(input int ch, input int h, input int l, input int p, input bit b);
    int k;
    drive_cfg(ch, h, l, p, b);
    k = 0;
    while (!cfg_ready && k < 20) begin
      step();
      k++;
    end
    check("wr_ready", 32'(cfg_ready), 32'd1);
    step();
    cfg_valid = 1'b0;
  endtask

  vec_t vt[6];
  logic [15:0] pc, pt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = '0; cfg_valid = 1'b0; cfg_chan = '0;
    cfg_high = '0; cfg_low = '0; cfg_phase = '0; cfg_bypass = 1'b0;
    step(); step();
    for (int c = 0; c < 4; c++) begin
      cfg_chan = 2'(c);
      #1;
      check($sformatf("rst_ready%0d", c), 32'(cfg_ready), (c < CH) ? 32'd1 : 32'd0);
    end
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_tick", 32'(period_tick), 32'd0);
    reset = 1'b0;

    // {ch, high, low, phase, cycles, zero-latency, period, high cycles}
    vt[0] = '{0, 2,   1, 0, 12,  1, 3,   2};
    vt[1] = '{1, 3,   3, 5, 20,  6, 6,   3};
    vt[2] = '{0, 0,   0, 0, 10,  1, 2,   1};
    vt[3] = '{2, 1,   4, 2, 15,  3, 5,   1};
    vt[4] = '{1, 255, 1, 0, 260, 1, 256, 255};
    vt[5] = '{2, 5,   0, 1, 14,  2, 6,   5};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      write_cfg(vt[i].ch, vt[i].h, vt[i].l, vt[i].p, 1'b0);
      step();
      en[vt[i].ch] = 1'b1;
      for (int j = 0; j < vt[i].n; j++) begin
        int m;
        if (j < vt[i].lat) begin
          sb_push(vt[i].ch, 1'b0, 1'b0, $sformatf("v%0d j%0d", i, j));
        end else begin
          m = (j - vt[i].lat) % vt[i].per;
          sb_push(vt[i].ch, m < vt[i].hi, m == vt[i].per - 1, $sformatf("v%0d j%0d", i, j));
        end
        sb_step();
      end
      en = '0;
      sb_push(vt[i].ch, 1'b0, 1'b0, $sformatf("v%0d en_off", i));
      sb_step();
    end

    // Reconfigure mid-HIGH: old period completes, new one starts at the boundary.
    do_reset();
    write_cfg(0, 2, 1, 0, 1'b0);
    step();
    en[0] = 1'b1;
    pc = 16'b0110100001_000000;
    pt = 16'b0001000010_000000;
    for (int j = 0; j < 10; j++) begin
      if (j == 2) begin
        drive_cfg(0, 1, 4, 3, 1'b0);
        check("seqA wr1_ready", 32'(cfg_ready), 32'd1);
      end
      if (j == 3) begin
        drive_cfg(0, 7, 7, 0, 1'b0);
        check("seqA wr2_ready", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
      end
      sb_push(0, pc[15-j], pt[15-j], $sformatf("seqA j%0d", j));
      sb_step();
      cfg_valid = 1'b0;
    end
    check("seqA ready_after", 32'(cfg_ready), 32'd1);

    // Reset on the final LOW cycle with a pending write outstanding.
    do_reset();
    write_cfg(0, 1, 4, 0, 1'b0);
    step();
    en[0] = 1'b1;
    pc = 16'b01000001010_00000;
    pt = 16'b00000000101_00000;
    for (int j = 0; j < 11; j++) begin
      if (j == 2) drive_cfg(0, 3, 3, 0, 1'b0);
      if (j == 5) reset = 1'b1;
      if (j == 6) begin
        reset = 1'b0;
        cfg_chan = 2'd0;
        #1;
        check("seqB ready_post_rst", 32'(cfg_ready), 32'd1);
      end
      sb_push(0, pc[15-j], pt[15-j], $sformatf("seqB j%0d", j));
      sb_step();
      cfg_valid = 1'b0;
    end

    // Bypass on ch2 mid-run while ch0 keeps dividing by 3.
    do_reset();
    write_cfg(0, 2, 1, 0, 1'b0);
    write_cfg(2, 2, 2, 0, 1'b0);
    step();
    en = 3'b101;
    pc = 16'b0110011111111111;
    pt = 16'b0000111111111111;
    for (int j = 0; j < 16; j++) begin
      int m;
      if (j == 2) begin
        drive_cfg(2, 2, 2, 0, 1'b1);
        check("seqC wr_ready", 32'(cfg_ready), 32'd1);
      end
      sb_push(2, pc[15-j], pt[15-j], $sformatf("seqC ch2 j%0d", j));
      if (j < 1) begin
        sb_push(0, 1'b0, 1'b0, $sformatf("seqC ch0 j%0d", j));
      end else begin
        m = (j - 1) % 3;
        sb_push(0, m < 2, m == 2, $sformatf("seqC ch0 j%0d", j));
      end
      sb_step();
      cfg_valid = 1'b0;
    end
    check("seqC ch1_idle", 32'(cout[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
